pe_sad: RTL and testbench

- Parametrised successor to the single-pixel absolute-difference PE: same search-window / template-block pixel shift registers and combinational AD output.
- Pixel width and AD approximation mode are selectable.
- Adds a pipelined per-PE SAD accumulator that sums BLK_N absolute differences and emits a one-cycle-valid result.
- Instanced in the full-search PE array; the motion-vector comparator consumes sad/sad_vld directly, with no external adder tree.

---
 rtl/pe_sad.sv | 105 ++++++++++
 tb/tb_pe_sad.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pe_sad.sv
// Absolute-difference PE with selectable pixel width and AD approximation.
// A two-stage accumulator sums BLK_N samples into a one-cycle-valid SAD result.
module pe_sad #(
  parameter int PIX_W    = 8,
  parameter int AD_MODE  = 0,
  parameter int MSB_BITS = 4,
  parameter int BLK_N    = 16,
  localparam int SAD_W   = PIX_W + $clog2(BLK_N)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en_sw,
  input  logic             en_tb,
  input  logic [PIX_W-1:0] pel_sw,
  input  logic [PIX_W-1:0] pel_tb,
  output logic [PIX_W-1:0] nxt_sw,
  output logic [PIX_W-1:0] nxt_tb,
  output logic [PIX_W-1:0] ad,
  input  logic             acc_en,
  input  logic             acc_clr,
  output logic [SAD_W-1:0] sad,
  output logic             sad_vld
);

  localparam int CNT_W    = $clog2(BLK_N);
  localparam int LSB_BITS = PIX_W - MSB_BITS;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      nxt_sw <= '0;
      nxt_tb <= '0;
    end else begin
      if (en_sw) nxt_sw <= pel_sw;
      if (en_tb) nxt_tb <= pel_tb;
    end
  end

  generate
    if (AD_MODE == 0) begin : g_full
      assign ad = (nxt_sw >= nxt_tb) ? (nxt_sw - nxt_tb) : (nxt_tb - nxt_sw);
    end else begin : g_msb
      logic [MSB_BITS-1:0] msb_sw;
      logic [MSB_BITS-1:0] msb_tb;
      logic [MSB_BITS-1:0] msb_ad;
      assign msb_sw = nxt_sw[PIX_W-1 -: MSB_BITS];
      assign msb_tb = nxt_tb[PIX_W-1 -: MSB_BITS];
      assign msb_ad = (msb_sw >= msb_tb) ? (msb_sw - msb_tb) : (msb_tb - msb_sw);
      if (AD_MODE == 1) begin : g_msb_only
        assign ad = {{LSB_BITS{1'b0}}, msb_ad};
      end else begin : g_hybrid
        // Low bits only flag disagreement, so a cheap XOR stands in for a subtract.
        assign ad = {msb_ad, nxt_sw[LSB_BITS-1:0] ^ nxt_tb[LSB_BITS-1:0]};
      end
    end
  endgenerate

  // Stage 1: register the sample and its qualifier
  logic [PIX_W-1:0] ad_p1;
  logic             vld_p1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ad_p1  <= '0;
      vld_p1 <= 1'b0;
    end else begin
      ad_p1  <= ad;
      vld_p1 <= acc_en & ~acc_clr;
    end
  end

  // Stage 2: accumulate, emit on the BLK_N-th sample
  logic [SAD_W-1:0] acc_p2;
  logic [SAD_W-1:0] sum_p2;
  logic [CNT_W-1:0] cnt_p2;
  logic             last_p2;

  assign sum_p2  = acc_p2 + SAD_W'(ad_p1);
  assign last_p2 = (cnt_p2 == CNT_W'(BLK_N - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_p2  <= '0;
      cnt_p2  <= '0;
      sad     <= '0;
      sad_vld <= 1'b0;
    end else begin
      sad_vld <= 1'b0;
      if (acc_clr) begin
        acc_p2 <= '0;
        cnt_p2 <= '0;
      end else if (vld_p1) begin
        if (last_p2) begin
          sad     <= sum_p2;
          sad_vld <= 1'b1;
          acc_p2  <= '0;
          cnt_p2  <= '0;
        end else begin
          acc_p2 <= sum_p2;
          cnt_p2 <= cnt_p2 + CNT_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_pe_sad.sv
// Bench for pe_sad: four instances (modes 0/1/2, BLK_N 16 and 4) against a
// sample-list reference model, plus directed literal expectations.
module tb_pe_sad;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       en_sw = 1'b0, en_tb = 1'b0, acc_en = 1'b0, acc_clr = 1'b0;
  logic [7:0] pel_sw = '0, pel_tb = '0;

  logic [7:0]  nsw_w [4];
  logic [7:0]  ntb_w [4];
  logic [7:0]  ad_w  [4];
  logic [3:0]  vld_w;
  logic [11:0] sad0;
  logic [9:0]  sad1, sad2, sad3;

  always #5 clk = ~clk;

  pe_sad #(.PIX_W(8), .AD_MODE(0), .MSB_BITS(4), .BLK_N(16)) u_d0 (
    .clk(clk), .rst_n(rst_n), .en_sw(en_sw), .en_tb(en_tb), .pel_sw(pel_sw), .pel_tb(pel_tb),
    .nxt_sw(nsw_w[0]), .nxt_tb(ntb_w[0]), .ad(ad_w[0]), .acc_en(acc_en), .acc_clr(acc_clr),
    .sad(sad0), .sad_vld(vld_w[0]));
  pe_sad #(.PIX_W(8), .AD_MODE(0), .MSB_BITS(4), .BLK_N(4)) u_d1 (
    .clk(clk), .rst_n(rst_n), .en_sw(en_sw), .en_tb(en_tb), .pel_sw(pel_sw), .pel_tb(pel_tb),
    .nxt_sw(nsw_w[1]), .nxt_tb(ntb_w[1]), .ad(ad_w[1]), .acc_en(acc_en), .acc_clr(acc_clr),
    .sad(sad1), .sad_vld(vld_w[1]));
  pe_sad #(.PIX_W(8), .AD_MODE(1), .MSB_BITS(4), .BLK_N(4)) u_d2 (
    .clk(clk), .rst_n(rst_n), .en_sw(en_sw), .en_tb(en_tb), .pel_sw(pel_sw), .pel_tb(pel_tb),
    .nxt_sw(nsw_w[2]), .nxt_tb(ntb_w[2]), .ad(ad_w[2]), .acc_en(acc_en), .acc_clr(acc_clr),
    .sad(sad2), .sad_vld(vld_w[2]));
  pe_sad #(.PIX_W(8), .AD_MODE(2), .MSB_BITS(4), .BLK_N(4)) u_d3 (
    .clk(clk), .rst_n(rst_n), .en_sw(en_sw), .en_tb(en_tb), .pel_sw(pel_sw), .pel_tb(pel_tb),
    .nxt_sw(nsw_w[3]), .nxt_tb(ntb_w[3]), .ad(ad_w[3]), .acc_en(acc_en), .acc_clr(acc_clr),
    .sad(sad3), .sad_vld(vld_w[3]));

  int n_cmp = 0;
  int n_bad = 0;
  int p1    = 0;

  int mode_a [4] = '{0, 0, 1, 2};
  int blk_a  [4] = '{16, 4, 4, 4};

  // Reference state: pixel registers, open block (sum/count), a finished
  // block waiting one edge to be published, and the published result.
  int m_sw = 0, m_tb = 0;
  int bsum [4];
  int bcnt [4];
  int pend [4];
  bit pend_v [4];
  int e_sad [4];
  bit e_vld [4];

  function automatic int absd(input int a, input int b);
    return (a > b) ? a - b : b - a;
  endfunction

  function automatic int model_ad(input int m, input int sw, input int tb);
    case (m)
      0:       return absd(sw, tb);
      1:       return absd(sw >> 4, tb >> 4);
      default: return (absd(sw >> 4, tb >> 4) << 4) | ((sw ^ tb) & 15);
    endcase
  endfunction

  function automatic int sad_of(input int d);
    case (d)
      0:       return int'(sad0);
      1:       return int'(sad1);
      2:       return int'(sad2);
      default: return int'(sad3);
    endcase
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  initial begin
    foreach (bsum[d]) begin
      bsum[d] = 0; bcnt[d] = 0; pend[d] = 0; pend_v[d] = 0; e_sad[d] = 0; e_vld[d] = 0;
    end
  end

  // Reference model and per-cycle compare
  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      m_sw = 0; m_tb = 0;
      for (int d = 0; d < 4; d++) begin
        bsum[d] = 0; bcnt[d] = 0; pend_v[d] = 0; e_sad[d] = 0; e_vld[d] = 0;
      end
    end else begin
      for (int d = 0; d < 4; d++) begin
        int ad_now;
        ad_now = model_ad(mode_a[d], m_sw, m_tb);
        e_vld[d] = 1'b0;
        if (pend_v[d] && !acc_clr) begin
          e_sad[d] = pend[d];
          e_vld[d] = 1'b1;
        end
        pend_v[d] = 1'b0;
        if (acc_clr) begin
          bsum[d] = 0; bcnt[d] = 0;
        end else if (acc_en) begin
          bsum[d] += ad_now;
          bcnt[d]++;
          if (bcnt[d] == blk_a[d]) begin
            pend[d] = bsum[d]; pend_v[d] = 1'b1; bsum[d] = 0; bcnt[d] = 0;
          end
        end
      end
      if (en_sw) m_sw = int'(pel_sw);
      if (en_tb) m_tb = int'(pel_tb);
      #2;
      if (rst_n) begin
        for (int d = 0; d < 4; d++) begin
          chk($sformatf("nxt_sw[%0d]", d), int'(nsw_w[d]), m_sw);
          chk($sformatf("nxt_tb[%0d]", d), int'(ntb_w[d]), m_tb);
          chk($sformatf("ad[%0d]", d), int'(ad_w[d]), model_ad(mode_a[d], m_sw, m_tb));
          chk($sformatf("sad[%0d]", d), sad_of(d), e_sad[d]);
          chk($sformatf("sad_vld[%0d]", d), int'(vld_w[d]), int'(e_vld[d]));
        end
        if (vld_w[1]) p1++;
      end
    end
  end

  task automatic cyc(input int sw, input int tb, input bit ae, input bit clr);
    @(negedge clk);
    pel_sw  = 8'(sw);
    pel_tb  = 8'(tb);
    en_sw   = 1'b1;
    en_tb   = 1'b1;
    acc_en  = ae;
    acc_clr = clr;
  endtask

  initial begin
    int p0;
    repeat (2) @(negedge clk);
    chk("rst_sad0", int'(sad0), 0);
    chk("rst_vld", int'(vld_w), 0);
    chk("rst_nxt_sw", int'(nsw_w[0]), 0);
    rst_n = 1'b1;

    // AD modes, both input orders, and equal inputs
    cyc('hA7, 'h3C, 0, 0);
    @(negedge clk);
    chk("ad_m0", int'(ad_w[0]), 'h6B);
    chk("ad_m1", int'(ad_w[2]), 'h07);
    chk("ad_m2", int'(ad_w[3]), 'h7B);
    cyc('h3C, 'hA7, 0, 0);
    @(negedge clk);
    chk("ad_m0_swap", int'(ad_w[0]), 'h6B);
    chk("ad_m1_swap", int'(ad_w[2]), 'h07);
    chk("ad_m2_swap", int'(ad_w[3]), 'h7B);
    cyc('h55, 'h55, 0, 0);
    @(negedge clk);
    chk("ad_m0_eq", int'(ad_w[0]), 0);

    // Full block 10,20,30,255 on BLK_N=4
    cyc(10, 0, 0, 0);
    cyc(20, 0, 1, 0);
    cyc(30, 0, 1, 0);
    cyc(255, 0, 1, 0);
    cyc(0, 0, 1, 0);
    cyc(0, 0, 0, 0);
    chk("blk_vld_early", int'(vld_w[1]), 0);
    @(negedge clk);
    chk("blk_vld", int'(vld_w[1]), 1);
    chk("blk_sad", int'(sad1), 315);
    @(negedge clk);
    chk("blk_vld_after", int'(vld_w[1]), 0);
    chk("blk_sad_hold", int'(sad1), 315);

    // Back-to-back blocks with a 3-cycle gap after sample 2
    p0 = p1;
    cyc(1, 0, 0, 0);
    cyc(1, 0, 1, 0);
    cyc(1, 0, 1, 0);
    repeat (3) cyc(1, 0, 0, 0);
    repeat (6) cyc(1, 0, 1, 0);
    cyc(0, 0, 0, 0);
    cyc(0, 0, 0, 0);
    @(negedge clk);
    chk("gap_pulses", p1 - p0, 2);
    chk("gap_sad", int'(sad1), 4);

    // acc_clr: dropped sample, clean block of 5s, suppressed completion of 7s
    p0 = p1;
    cyc(5, 0, 0, 1);
    cyc(5, 0, 1, 0);
    cyc(5, 0, 1, 0);
    cyc(5, 0, 1, 1);
    repeat (3) cyc(5, 0, 1, 0);
    cyc(7, 0, 1, 0);
    repeat (4) cyc(7, 0, 1, 0);
    cyc(0, 0, 0, 1);
    cyc(0, 0, 0, 0);
    cyc(0, 0, 0, 0);
    @(negedge clk);
    chk("clr_pulses", p1 - p0, 1);
    chk("clr_sad", int'(sad1), 20);

    // Maximum value on the default configuration
    cyc(255, 0, 0, 1);
    repeat (16) cyc(255, 0, 1, 0);
    cyc(0, 0, 0, 0);
    cyc(0, 0, 0, 0);
    @(negedge clk);
    chk("max_sad16", int'(sad0), 4080);
    chk("max_sad4", int'(sad1), 1020);

    // Asynchronous reset mid-block
    cyc(9, 3, 0, 0);
    cyc(9, 3, 1, 0);
    cyc(9, 3, 1, 0);
    @(negedge clk);
    rst_n = 1'b0; en_sw = 1'b0; en_tb = 1'b0; acc_en = 1'b0; acc_clr = 1'b0;
    #1;
    chk("arst_nxt_sw", int'(nsw_w[0]), 0);
    chk("arst_nxt_tb", int'(ntb_w[0]), 0);
    chk("arst_ad", int'(ad_w[0]), 0);
    chk("arst_sad0", int'(sad0), 0);
    chk("arst_sad1", int'(sad1), 0);
    chk("arst_vld", int'(vld_w), 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("hold_nxt_sw", int'(nsw_w[1]), 0);
    chk("hold_nxt_tb", int'(ntb_w[1]), 0);
    chk("hold_sad1", int'(sad1), 0);

    // Randomised traffic
    for (int i = 0; i < 800; i++) begin
      @(negedge clk);
      pel_sw  = 8'($urandom);
      pel_tb  = 8'($urandom);
      en_sw   = ($urandom_range(3) != 0);
      en_tb   = ($urandom_range(3) != 0);
      acc_en  = ($urandom_range(4) != 0);
      acc_clr = ($urandom_range(31) == 0);
    end
    @(negedge clk);
    acc_en = 1'b0; acc_clr = 1'b0;
    repeat (4) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
